// File: rtl/score_text_ctrl.sv
// Score/message text controller: 8-slot glyph buffer, score BCD converter,
// blink masking and one-cycle poll scheduling for a shared glyph renderer.
module score_text_ctrl #(
   parameter logic [10:0] ORIGIN_X     = 11'd192,
   parameter logic [9:0]  ORIGIN_Y     = 10'd16,
   parameter logic [3:0]  SCALE        = 4'd2,
   parameter int          PITCH_SHIFT  = 5,
   parameter logic [24:0] BLINK_CYCLES = 25'd12_500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  ScoreL,
   input  logic [6:0]  ScoreR,
   input  logic        UpdReq,
   output logic        UpdAck,
   output logic        Busy,
   input  logic        WrEn,
   input  logic [1:0]  WrAddr,
   input  logic [5:0]  WrData,
   input  logic        BlinkEn,
   input  logic [9:0]  PollX,
   input  logic [8:0]  PollY,
   output logic [5:0]  CharValue,
   output logic [10:0] CharX,
   output logic [9:0]  CharY,
   output logic [3:0]  CharScale,
   output logic [9:0]  PollXd,
   output logic [8:0]  PollYd
);

   localparam logic [5:0]  SPACE = 6'd36;
   localparam logic [10:0] SPAN  = 11'(8 << PITCH_SHIFT);

   typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_rem_l;
   logic [6:0]  r_rem_r;
   logic [3:0]  r_tens_l;
   logic [3:0]  r_tens_r;
   logic        r_busy;
   logic        r_ack;
   logic [5:0]  r_slot [8];
   logic [24:0] r_blink_cnt;
   logic        r_blink_on;
   logic [5:0]  r_char_value;
   logic [10:0] r_char_x;
   logic [9:0]  r_poll_xd;
   logic [8:0]  r_poll_yd;

   logic [6:0]  w_clamp_l;
   logic [6:0]  w_clamp_r;
   logic [10:0] w_relx;
   logic        w_in_range;
   logic [2:0]  w_idx;
   logic        w_msg;
   logic [5:0]  w_val;
   logic [10:0] w_slot_x;

   assign w_clamp_l = (ScoreL > 7'd99) ? 7'd99 : ScoreL;
   assign w_clamp_r = (ScoreR > 7'd99) ? 7'd99 : ScoreR;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (UpdReq) w_next = CONV_L;
         CONV_L:  if (r_rem_l < 7'd10) w_next = CONV_R;
         CONV_R:  if (r_rem_r < 7'd10) w_next = COMMIT;
         COMMIT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Repeated subtraction: one decade per cycle per side
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rem_l  <= '0;
         r_rem_r  <= '0;
         r_tens_l <= '0;
         r_tens_r <= '0;
         r_busy   <= 1'b0;
         r_ack    <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (r_state == IDLE && UpdReq) begin
            r_rem_l  <= w_clamp_l;
            r_rem_r  <= w_clamp_r;
            r_tens_l <= '0;
            r_tens_r <= '0;
            r_busy   <= 1'b1;
         end
         if (r_state == CONV_L && r_rem_l >= 7'd10) begin
            r_rem_l  <= r_rem_l - 7'd10;
            r_tens_l <= r_tens_l + 4'd1;
         end
         if (r_state == CONV_R && r_rem_r >= 7'd10) begin
            r_rem_r  <= r_rem_r - 7'd10;
            r_tens_r <= r_tens_r + 4'd1;
         end
         if (r_state == COMMIT) begin
            r_busy <= 1'b0;
            r_ack  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++)
            r_slot[i] <= (i == 1 || i == 7) ? 6'd0 : SPACE;
      end else begin
         if (r_state == COMMIT) begin
            r_slot[0] <= (r_tens_l == 4'd0) ? SPACE : {2'b00, r_tens_l};
            r_slot[1] <= r_rem_l[5:0];
            r_slot[6] <= (r_tens_r == 4'd0) ? SPACE : {2'b00, r_tens_r};
            r_slot[7] <= r_rem_r[5:0];
         end
         if (WrEn)
            r_slot[3'd2 + {1'b0, WrAddr}] <= WrData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (!BlinkEn) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLINK_CYCLES - 25'd1) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 25'd1;
      end
   end

   assign w_relx     = {1'b0, PollX} - ORIGIN_X;
   assign w_in_range = ({1'b0, PollX} >= ORIGIN_X) && (w_relx < SPAN);
   assign w_idx      = w_relx[PITCH_SHIFT +: 3];
   assign w_msg      = (w_idx >= 3'd2) && (w_idx <= 3'd5);
   assign w_val      = (w_msg && !r_blink_on) ? SPACE : r_slot[w_idx];
   assign w_slot_x   = ORIGIN_X + (11'(w_idx) << PITCH_SHIFT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_char_value <= SPACE;
         r_char_x     <= ORIGIN_X;
         r_poll_xd    <= '0;
         r_poll_yd    <= '0;
      end else begin
         r_char_value <= w_in_range ? w_val : SPACE;
         r_char_x     <= w_in_range ? w_slot_x : ORIGIN_X;
         r_poll_xd    <= PollX;
         r_poll_yd    <= PollY;
      end
   end

   assign UpdAck    = r_ack;
   assign Busy      = r_busy;
   assign CharValue = r_char_value;
   assign CharX     = r_char_x;
   assign CharY     = ORIGIN_Y;
   assign CharScale = SCALE;
   assign PollXd    = r_poll_xd;
   assign PollYd    = r_poll_yd;

endmodule
